// File: rtl/rf_cmd_sequencer.sv
// Command front-end for the sprite/background register file: expands bus commands into
// single-field writes or a read, with ack timeout. `define RF_CMD_SEQ_STATS_EN adds stat counters.
module rf_cmd_sequencer #(
  parameter int NUM_REGS       = 21,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TO_W           = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_reg,
  input  logic [29:0] cmd_data,
  output logic [4:0]  rf_n_reg,
  output logic [29:0] rf_data,
  output logic        rf_written,
  output logic [1:0]  rf_selectField,
  input  logic        rf_done,
  input  logic [29:0] rf_readData,
  output logic        rsp_valid,
  output logic [29:0] rsp_data,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy
`ifdef RF_CMD_SEQ_STATS_EN
  ,
  output logic [15:0] stat_writes,
  output logic [15:0] stat_errors
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_X, S_WR_Y, S_WR_OFF, S_WR_BG, S_RD_ISSUE, S_RD_CAP
  } state_e;

  localparam logic [1:0] OP_SPRITE = 2'b00;
  localparam logic [1:0] OP_BG     = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;

  localparam logic [1:0] SEL_X   = 2'b00;
  localparam logic [1:0] SEL_Y   = 2'b01;
  localparam logic [1:0] SEL_OFF = 2'b10;
  localparam logic [1:0] SEL_BG  = 2'b11;

  localparam logic [1:0] ERR_REG = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;
  localparam logic [1:0] ERR_OP  = 2'b11;

  localparam logic [5:0]      REG_LIMIT = 6'(NUM_REGS);
  localparam logic [TO_W-1:0] CNT_FIRST = TO_W'(1);
  localparam logic [TO_W-1:0] CNT_LAST  = TO_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [4:0]        nreg_q, nreg_d;
  logic [1:0]        sel_q, sel_d;
  logic [29:0]       data_q, data_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              rsp_v_q, rsp_v_d;
  logic [29:0]       rsp_d_q, rsp_d_d;

  logic in_write, ack, expired, accept, read_ok, sprite_ok;

  assign in_write  = (state_q == S_WR_X) || (state_q == S_WR_Y) ||
                     (state_q == S_WR_OFF) || (state_q == S_WR_BG);
  // The first cycle of every write state ignores rf_done, so a stale ack cannot complete it.
  assign ack       = in_write && (cnt_q != CNT_FIRST) && rf_done;
  assign expired   = in_write && !ack && (cnt_q == CNT_LAST);
  assign accept    = cmd_valid && cmd_ready;
  assign read_ok   = {1'b0, cmd_reg} < REG_LIMIT;
  assign sprite_ok = read_ok && (cmd_reg != 5'd0);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      state_q <= S_IDLE;
      nreg_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
      rsp_v_q <= 1'b0;
      rsp_d_q <= '0;
    end else begin
      state_q <= state_d;
      nreg_q  <= nreg_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      code_q  <= code_d;
      rsp_v_q <= rsp_v_d;
      rsp_d_q <= rsp_d_d;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    nreg_d  = nreg_q;
    sel_d   = sel_q;
    data_d  = data_q;
    cnt_d   = '0;
    err_d   = 1'b0;
    code_d  = code_q;
    rsp_v_d = 1'b0;
    rsp_d_d = rsp_d_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d = cmd_data;
          case (cmd_op)
            OP_SPRITE: begin
              if (sprite_ok) begin
                state_d = S_WR_X;
                nreg_d  = cmd_reg;
                sel_d   = SEL_X;
                cnt_d   = CNT_FIRST;
              end else begin
                err_d  = 1'b1;
                code_d = ERR_REG;
              end
            end
            OP_BG: begin
              state_d = S_WR_BG;
              nreg_d  = 5'd0;
              sel_d   = SEL_BG;
              cnt_d   = CNT_FIRST;
            end
            OP_READ: begin
              if (read_ok) begin
                state_d = S_RD_ISSUE;
                nreg_d  = cmd_reg;
              end else begin
                err_d  = 1'b1;
                code_d = ERR_REG;
              end
            end
            default: begin
              err_d  = 1'b1;
              code_d = ERR_OP;
            end
          endcase
        end
      end
      S_WR_X, S_WR_Y, S_WR_OFF, S_WR_BG: begin
        if (ack) begin
          case (state_q)
            S_WR_X: begin
              state_d = S_WR_Y;
              sel_d   = SEL_Y;
              cnt_d   = CNT_FIRST;
            end
            S_WR_Y: begin
              state_d = S_WR_OFF;
              sel_d   = SEL_OFF;
              cnt_d   = CNT_FIRST;
            end
            default: state_d = S_IDLE;
          endcase
        end else if (expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TO;
        end else begin
          cnt_d = cnt_q + CNT_FIRST;
        end
      end
      S_RD_ISSUE: state_d = S_RD_CAP;
      S_RD_CAP: begin
        state_d = S_IDLE;
        rsp_v_d = 1'b1;
        rsp_d_d = rf_readData;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    cmd_ready  = (state_q == S_IDLE) && !reset;
    busy       = state_q != S_IDLE;
    rf_written = in_write;
    rf_data    = in_write ? data_q : '0;
  end

  assign rf_n_reg       = nreg_q;
  assign rf_selectField = sel_q;
  assign rsp_valid      = rsp_v_q;
  assign rsp_data       = rsp_d_q;
  assign err            = err_q;
  assign err_code       = code_q;

`ifdef RF_CMD_SEQ_STATS_EN
  logic [15:0] stat_w_q, stat_e_q;

  // Saturating counters; err_d marks the edge that raises the err pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_w_q <= '0;
      stat_e_q <= '0;
    end else begin
      if (ack && (stat_w_q != 16'hFFFF)) stat_w_q <= stat_w_q + 16'd1;
      if (err_d && (stat_e_q != 16'hFFFF)) stat_e_q <= stat_e_q + 16'd1;
    end
  end

  assign stat_writes = stat_w_q;
  assign stat_errors = stat_e_q;
`endif

endmodule

// File: tb/tb_rf_cmd_sequencer.sv
// Randomized bench for rf_cmd_sequencer: a transaction-level model expands each command
// into an expected per-cycle trace plus the register-file stimulus, then compares the DUT.
`timescale 1ns/1ps
module tb_rf_cmd_sequencer;

  localparam int NUM_REGS = 21;
  localparam int TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_reg;
  logic [29:0] cmd_data;
  logic [4:0]  rf_n_reg;
  logic [29:0] rf_data;
  logic        rf_written;
  logic [1:0]  rf_selectField;
  logic        rf_done;
  logic [29:0] rf_readData;
  logic        rsp_valid;
  logic [29:0] rsp_data;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;
`ifdef RF_CMD_SEQ_STATS_EN
  logic [15:0] stat_writes;
  logic [15:0] stat_errors;
`endif

  always #5 clk = ~clk;

  rf_cmd_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_reg        (cmd_reg),
    .cmd_data       (cmd_data),
    .rf_n_reg       (rf_n_reg),
    .rf_data        (rf_data),
    .rf_written     (rf_written),
    .rf_selectField (rf_selectField),
    .rf_done        (rf_done),
    .rf_readData    (rf_readData),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .err            (err),
    .err_code       (err_code),
    .busy           (busy)
`ifdef RF_CMD_SEQ_STATS_EN
    ,
    .stat_writes    (stat_writes),
    .stat_errors    (stat_errors)
`endif
  );

  // One clock cycle: expected outputs plus the stimulus applied during it.
  typedef struct {
    logic        ready, busy, written;
    logic [4:0]  nreg;
    logic [1:0]  sel;
    logic [29:0] data;
    logic        err;
    logic [1:0]  code;
    logic        rsp_v;
    logic [29:0] rsp_d;
    logic [15:0] sw, se;
    logic        valid;
    logic [1:0]  op;
    logic [4:0]  rg;
    logic [29:0] cd;
    logic        done;
    logic [29:0] rd;
  } cyc_t;

  cyc_t trace[$];

  logic [4:0]  m_nreg;
  logic [1:0]  m_sel;
  logic [1:0]  m_code;
  logic [15:0] m_sw, m_se;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic cyc_t base(input bit in_busy);
    cyc_t c;
    c.ready   = !in_busy;
    c.busy    = in_busy;
    c.written = 1'b0;
    c.nreg    = m_nreg;
    c.sel     = m_sel;
    c.data    = '0;
    c.err     = 1'b0;
    c.code    = m_code;
    c.rsp_v   = 1'b0;
    c.rsp_d   = '0;
    c.sw      = m_sw;
    c.se      = m_se;
    c.valid   = in_busy ? 1'($urandom_range(0, 1)) : 1'b0;
    c.op      = 2'($urandom_range(0, 3));
    c.rg      = 5'($urandom_range(0, 31));
    c.cd      = 30'($urandom);
    c.done    = 1'($urandom_range(0, 1));
    c.rd      = 30'($urandom);
    return c;
  endfunction

  // One field write: ack_at is the cycle (>=2) carrying rf_done, beyond TIMEOUT means never.
  // Returns 1 when the field times out.
  function automatic bit write_field(input logic [4:0] n, input logic [1:0] s,
                                     input logic [29:0] d, input int ack_at, input bit stale);
    cyc_t c;
    m_nreg = n;
    m_sel  = s;
    for (int j = 1; j <= TIMEOUT; j++) begin
      c = base(1'b1);
      c.written = 1'b1;
      c.data    = d;
      c.done    = (j == 1) ? stale : (j == ack_at);
      trace.push_back(c);
      if (j >= 2 && j == ack_at) begin
        if (m_sw != 16'hFFFF) m_sw++;
        return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic build_cmd(input logic [1:0] op, input logic [4:0] rg, input logic [29:0] cd,
                           input int d0, input int d1, input int d2, input logic [2:0] st,
                           input logic [29:0] rdv);
    cyc_t c;
    int   dl[3];
    bit   to;
    logic [1:0] bad;
    dl = '{d0, d1, d2};
    to  = 1'b0;
    bad = 2'b00;
    trace.delete();
    c = base(1'b0);
    c.valid = 1'b1;
    c.op    = op;
    c.rg    = rg;
    c.cd    = cd;
    trace.push_back(c);
    case (op)
      2'b00: begin
        if (rg != 0 && int'(rg) < NUM_REGS) begin
          for (int f = 0; f < 3 && !to; f++) to = write_field(rg, 2'(f), cd, dl[f], st[f]);
        end else bad = 2'b01;
      end
      2'b01: to = write_field(5'd0, 2'b11, cd, dl[0], st[0]);
      2'b10: begin
        if (int'(rg) < NUM_REGS) begin
          m_nreg = rg;
          c = base(1'b1);
          trace.push_back(c);
          c = base(1'b1);
          c.rd = rdv;
          trace.push_back(c);
        end else bad = 2'b01;
      end
      default: bad = 2'b11;
    endcase
    if (to) bad = 2'b10;
    if (bad != 2'b00) begin
      m_code = bad;
      if (m_se != 16'hFFFF) m_se++;
    end
    c = base(1'b0);
    c.err = (bad != 2'b00);
    if (op == 2'b10 && bad == 2'b00) begin
      c.rsp_v = 1'b1;
      c.rsp_d = rdv;
    end
    trace.push_back(c);
  endtask

  task automatic compare_cyc(input cyc_t e);
    check("cmd_ready", cmd_ready, e.ready);
    check("busy", busy, e.busy);
    check("rf_written", rf_written, e.written);
    check("rf_n_reg", rf_n_reg, e.nreg);
    check("rf_selectField", rf_selectField, e.sel);
    check("rf_data", rf_data, e.data);
    check("err", err, e.err);
    check("err_code", err_code, e.code);
    check("rsp_valid", rsp_valid, e.rsp_v);
    if (e.rsp_v) check("rsp_data", rsp_data, e.rsp_d);
`ifdef RF_CMD_SEQ_STATS_EN
    check("stat_writes", stat_writes, e.sw);
    check("stat_errors", stat_errors, e.se);
`endif
  endtask

  // Plays the first n trace entries (all when n < 0).
  task automatic play(input int n);
    int lim;
    lim = (n < 0) ? trace.size() : n;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      cmd_valid   = trace[i].valid;
      cmd_op      = trace[i].op;
      cmd_reg     = trace[i].rg;
      cmd_data    = trace[i].cd;
      rf_done     = trace[i].done;
      rf_readData = trace[i].rd;
      @(negedge clk);
      compare_cyc(trace[i]);
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [4:0] rg, input logic [29:0] cd,
                     input int d0, input int d1, input int d2, input logic [2:0] st,
                     input logic [29:0] rdv);
    build_cmd(op, rg, cd, d0, d1, d2, st, rdv);
    play(-1);
  endtask

  task automatic check_all_zero(input string tag, input logic exp_ready);
    check({tag, ".cmd_ready"}, cmd_ready, exp_ready);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".rf_written"}, rf_written, 1'b0);
    check({tag, ".rf_n_reg"}, rf_n_reg, 5'd0);
    check({tag, ".rf_selectField"}, rf_selectField, 2'd0);
    check({tag, ".rf_data"}, rf_data, 30'd0);
    check({tag, ".rsp_valid"}, rsp_valid, 1'b0);
    check({tag, ".rsp_data"}, rsp_data, 30'd0);
    check({tag, ".err"}, err, 1'b0);
    check({tag, ".err_code"}, err_code, 2'd0);
`ifdef RF_CMD_SEQ_STATS_EN
    check({tag, ".stat_writes"}, stat_writes, 16'd0);
    check({tag, ".stat_errors"}, stat_errors, 16'd0);
`endif
  endtask

  function automatic int rand_dly();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return $urandom_range(2, 4);
    if (r == 6) return TIMEOUT;
    if (r == 7) return TIMEOUT + 1;
    if (r == 8) return TIMEOUT - 1;
    return $urandom_range(2, TIMEOUT);
  endfunction

  initial begin
    #300us;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_reg     = '0;
    cmd_data    = '0;
    rf_done     = 1'b0;
    rf_readData = '0;
    m_nreg = '0;
    m_sel  = '0;
    m_code = '0;
    m_sw   = '0;
    m_se   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset", 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset", 1'b1);

    // Directed cases: ideal ack, background, read, bad reg/opcode, timeout, boundaries.
    run(2'b00, 5'd5, {10'd3, 10'd200, 10'd100}, 2, 2, 2, 3'b111, '0);
    run(2'b01, 5'd17, 30'h3FF, 2, 2, 2, 3'b111, '0);
    run(2'b10, 5'd7, 30'h0, 2, 2, 2, 3'b000, 30'h1234567);
    run(2'b00, 5'd21, 30'h155, 2, 2, 2, 3'b000, '0);
    run(2'b11, 5'd4, 30'h2AA, 2, 2, 2, 3'b000, '0);
    run(2'b00, 5'd3, 30'h0ABCDEF, TIMEOUT + 1, 2, 2, 3'b000, '0);
    run(2'b00, 5'd20, 30'h3000_0001, TIMEOUT, 3, TIMEOUT - 1, 3'b101, '0);
    run(2'b00, 5'd0, 30'h1, 2, 2, 2, 3'b000, '0);
    run(2'b10, 5'd0, 30'h0, 2, 2, 2, 3'b000, 30'h2222_3333);
    run(2'b10, 5'd20, 30'h0, 2, 2, 2, 3'b000, 30'h0FED_CBA9);
    run(2'b10, 5'd31, 30'h0, 2, 2, 2, 3'b000, 30'h1111_1111);
    run(2'b00, 5'd9, 30'h0777_7777, 2, 2, TIMEOUT + 1, 3'b111, '0);

    // Reset in cycle 4 of a SET_SPRITE with rf_done held high.
    build_cmd(2'b00, 5'd9, 30'h2AAA_AAAA, 2, 2, 2, 3'b111, '0);
    play(4);
    @(posedge clk); #1;
    reset     = 1'b1;
    rf_done   = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("mid_cmd_reset", 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset_release", 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("stale_done_idle", 1'b1);
    m_nreg = '0;
    m_sel  = '0;
    m_code = '0;
    m_sw   = '0;
    m_se   = '0;

    // Randomized commands against the model.
    for (int k = 0; k < 80; k++) begin
      run(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 30'($urandom),
          rand_dly(), rand_dly(), rand_dly(), 3'($urandom_range(0, 7)), 30'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_cmd_sequencer.md
Name: rf_cmd_sequencer

Overview:
Upstream command front-end for the sprite/background register file. Accepts one command per handshake (set sprite x/y/offset, set background, read register) and expands it into single-field write transactions (n_reg, data, written, selectField) or a read. Waits for the register file's done acknowledge, enforces a timeout, and returns read data and error status to the bus side.

Parameters:
NUM_REGS, 21, number of implemented registers; valid indices are 0..NUM_REGS-1, and reg 0 is background.
TIMEOUT_CYCLES, 15, maximum cycles written may stay high without an acknowledge.
TO_W, 4, timeout counter width; requires TIMEOUT_CYCLES < 2**TO_W.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  2  00 SET_SPRITE, 01 SET_BG, 10 READ, 11 reserved
cmd_reg  in  5  target register index; ignored for SET_BG
cmd_data  in  30  [9:0] x or background colour, [19:10] y, [29:20] offset
rf_n_reg  out  5  register index to register file
rf_data  out  30  data to register file; cmd_data passed through unmodified
rf_written  out  1  1 = write, 0 = read
rf_selectField  out  2  00 x, 01 y, 10 offset, 11 background
rf_done  in  1  write acknowledge from register file
rf_readData  in  30  registered read data from register file
rsp_valid  out  1  one-cycle pulse: rsp_data valid
rsp_data  out  30  captured read value
err  out  1  one-cycle error pulse
err_code  out  2  01 bad register, 10 timeout, 11 bad opcode; holds last error
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: synchronous and active-high. Takes priority over everything, including mid-command. Next state is IDLE and every output returns to 0: cmd_ready, rf_*, rsp_*, err, err_code, busy. The timeout counter clears. Any abandoned write is not retried.
- Accept: cmd_ready=1 only in IDLE and not during reset. A command is taken on an edge where cmd_valid & cmd_ready; cmd_reg, cmd_op and cmd_data are latched. There is no backpressure on rsp_valid or err.
- States: IDLE, WR_X, WR_Y, WR_OFF, WR_BG, RD_ISSUE, RD_CAP.
- SET_SPRITE, cmd_reg in 1..NUM_REGS-1: sequence WR_X -> WR_Y -> WR_OFF -> IDLE, with selectField 00/01/10.
- SET_SPRITE, cmd_reg = 0 or >= NUM_REGS: no write; err pulses next cycle with err_code=01; return to IDLE.
- SET_BG: WR_BG with n_reg=0, selectField=11, then IDLE.
- READ, valid index: RD_ISSUE drives rf_written=0 and rf_n_reg=reg. RD_CAP samples rf_readData at its ending edge. rsp_valid=1 in the following cycle, which is also IDLE.
- READ, invalid index: err with err_code=01; rsp_valid is not asserted.
- op 11: err with err_code=11; no register-file activity.
- Write states:
  - rf_written=1 with fields stable for the whole state.
  - rf_done is ignored in the first cycle of each write state (guards against a stale acknowledge). The counter starts there at 1.
  - From the second cycle, rf_done=1 at an edge completes the field. The next state then starts with a fresh first cycle.
  - If the counter reaches TIMEOUT_CYCLES without an acknowledge: rf_written drops to 0, err pulses with err_code=10, remaining fields are abandoned, and the next state is IDLE.
- Idle and read values: in IDLE, rf_written=0 and rf_n_reg/rf_selectField hold their last values. In read states, rf_data=0.
- Latency, ideal acknowledge (rf_done high from the second cycle of every write):
  - SET_SPRITE: accept at cycle 0; writes in cycles 1-2, 3-4, 5-6; cmd_ready=1 at cycle 7.
  - SET_BG: cmd_ready again at cycle 3.
  - READ: rsp_valid at cycle 3.
- Simultaneous events: rf_done and timeout on the same edge resolve as done, not error. cmd_valid during busy is held off by cmd_ready=0.

Optional Feature:
RF_CMD_SEQ_STATS_EN.
- Defined: adds outputs stat_writes[15:0] and stat_errors[15:0].
  - stat_writes increments on each acknowledged field write.
  - stat_errors increments on each err pulse.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- SET_SPRITE reg=5, data {offset=10'd3, y=10'd200, x=10'd100}, rf model acks in 2nd cycle -> rf writes (5,00,data), (5,01,data), (5,10,data) in cycles 1-2, 3-4, 5-6; cmd_ready=1 at cycle 7; err never 1.
- SET_BG data[9:0]=10'h3FF -> one write, n_reg=0, selectField=11; busy for 2 cycles.
- READ reg=7, model returns 30'h1234567 -> rsp_valid=1 at cycle 3 with rsp_data=30'h1234567, rf_written=0 throughout.
- SET_SPRITE reg=21, then op=11 -> no rf_written assertion; err pulses with err_code=01, then 11.
- SET_SPRITE reg=3, rf_done held low -> rf_written high 15 cycles in WR_X, then err with err_code=10; WR_Y never entered; IDLE next.
- Reset asserted in cycle 4 of a SET_SPRITE, rf_done held at 1 -> all outputs 0 next cycle; cmd_ready=1 the cycle after reset deasserts; a stale rf_done=1 causes no write completion. With RF_CMD_SEQ_STATS_EN defined, stat_writes=0 after the reset.
